risc16_mem_mmio: RTL and testbench

Parametrised, synthesizable memory and MMIO subsystem for the risc16 cores, replacing the fixed bench-only memory model. It provides an instruction read port and a data read/write port over one byte-addressed, big-endian memory. Both ports use a req/ack handshake with a configurable wait-state count. A bank of NUM_LED 16-bit memory-mapped output registers with byte enables and read-back drives board LEDs.

---
 rtl/risc16_mem_mmio.sv | 168 ++++++++++++++++
 tb/tb_risc16_mem_mmio.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_mem_mmio.sv
// Byte-addressed big-endian memory with an instruction fetch port, a data port
// and a bank of 16-bit MMIO LED registers; both ports use req/ack with wait states.
module risc16_mem_mmio #(
    parameter int          ADDR_W      = 16,
    parameter int          MEM_BYTES   = 65536,
    parameter int          NUM_LED     = 3,
    parameter int unsigned MMIO_BASE   = 32'h0200,
    parameter int          WAIT_CYCLES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ireq,
    input  logic [ADDR_W-1:0]     iaddr,
    output logic [15:0]           idin,
    output logic                  iack,
    input  logic                  dreq,
    input  logic                  dwe,
    input  logic [1:0]            dbe,
    input  logic [ADDR_W-1:0]     daddr,
    input  logic [15:0]           ddout,
    output logic [15:0]           ddin,
    output logic                  dack,
    output logic [16*NUM_LED-1:0] led
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic {IDLE, BUSY} state_e;

    logic [ADDR_W-1:0] i_a, d_a;
    logic              d_we;
    logic [1:0]        d_be;
    logic [15:0]       d_wd;
    logic              i_ack, d_ack;

    logic [7:0]                mem [MEM_BYTES];
    logic [NUM_LED-1:0][15:0]  led_q;

    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            assign i_ack = ireq & rst_n;
            assign d_ack = dreq & rst_n;
            assign i_a   = iaddr;
            assign d_a   = daddr;
            assign d_we  = dwe;
            assign d_be  = dbe;
            assign d_wd  = ddout;
        end else begin : g_wait
            // Index 0 is the fetch port, index 1 the data port.
            state_e            st_q  [2];
            logic [3:0]        cnt_q [2];
            logic [1:0]        ack_q;
            logic [1:0]        req;
            logic [ADDR_W-1:0] ia_q, da_q;
            logic              dwe_q;
            logic [1:0]        dbe_q;
            logic [15:0]       dwd_q;

            assign req = {dreq, ireq};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int p = 0; p < 2; p++) begin
                        st_q[p]  <= IDLE;
                        cnt_q[p] <= 4'd0;
                    end
                    ack_q <= 2'b00;
                    ia_q  <= '0;
                    da_q  <= '0;
                    dwe_q <= 1'b0;
                    dbe_q <= 2'b00;
                    dwd_q <= 16'h0000;
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        case (st_q[p])
                            IDLE: if (req[p]) begin
                                st_q[p]  <= BUSY;
                                cnt_q[p] <= 4'(WAIT_CYCLES - 1);
                                ack_q[p] <= (WAIT_CYCLES == 1);
                            end
                            BUSY: if (cnt_q[p] == 4'd0) begin
                                st_q[p]  <= IDLE;
                                ack_q[p] <= 1'b0;
                            end else begin
                                cnt_q[p] <= cnt_q[p] - 4'd1;
                                ack_q[p] <= (cnt_q[p] == 4'd1);
                            end
                            default: st_q[p] <= IDLE;
                        endcase
                    end
                    // Capture the request so a dropped dreq still completes as issued.
                    if (st_q[0] == IDLE && ireq) ia_q <= iaddr;
                    if (st_q[1] == IDLE && dreq) begin
                        da_q  <= daddr;
                        dwe_q <= dwe;
                        dbe_q <= dbe;
                        dwd_q <= ddout;
                    end
                end
            end

            assign i_ack = ack_q[0];
            assign d_ack = ack_q[1];
            assign i_a   = ia_q;
            assign d_a   = da_q;
            assign d_we  = dwe_q;
            assign d_be  = dbe_q;
            assign d_wd  = dwd_q;
        end
    endgenerate

    logic [AW-1:0]     ie, io, de, dodd;
    logic [ADDR_W-1:0] d_wa;
    logic [31:0]       d_wa32;
    logic              d_hit;
    int                d_idx;
    logic [15:0]       mmio_rd, d_rd;
    logic              mem_wr, led_wr;

    assign ie     = {i_a[AW-1:1], 1'b0};
    assign io     = {i_a[AW-1:1], 1'b1};
    assign de     = {d_a[AW-1:1], 1'b0};
    assign dodd   = {d_a[AW-1:1], 1'b1};
    assign d_wa   = {d_a[ADDR_W-1:1], 1'b0};
    assign d_wa32 = 32'(d_wa);
    assign d_hit  = (d_wa32 >= MMIO_BASE) && (d_wa32 < MMIO_BASE + 32'(2 * NUM_LED));
    assign d_idx  = int'((d_wa32 - MMIO_BASE) >> 1);

    always_comb begin
        mmio_rd = 16'h0000;
        for (int k = 0; k < NUM_LED; k++)
            if (d_idx == k) mmio_rd = led_q[k];
    end

    assign d_rd   = d_hit ? mmio_rd : {mem[de], mem[dodd]};
    assign idin   = i_ack ? {mem[ie], mem[io]} : 16'h0000;
    assign ddin   = d_ack ? d_rd : 16'h0000;
    assign iack   = i_ack;
    assign dack   = d_ack;
    assign mem_wr = d_ack & d_we & ~d_hit;
    assign led_wr = d_ack & d_we & d_hit;

    // No reset on the array: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            if (d_be[1]) mem[de]   <= d_wd[15:8];
            if (d_be[0]) mem[dodd] <= d_wd[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else if (led_wr) begin
            for (int k = 0; k < NUM_LED; k++) begin
                if (d_idx == k) begin
                    if (d_be[1]) led_q[k][15:8] <= d_wd[15:8];
                    if (d_be[0]) led_q[k][7:0]  <= d_wd[7:0];
                end
            end
        end
    end

    assign led = led_q;

    logic unused_ok;
    assign unused_ok = ^{i_a, d_a[0]};
endmodule

// File: tb/tb_risc16_mem_mmio.sv
// Three DUT configurations (W=0 full memory, W=3 full memory, W=4 256-byte memory)
// checked every cycle against a byte-array/timestamp model plus directed literals.
module tb_risc16_mem_mmio;
    localparam int NI = 3;
    localparam int WT [NI] = '{0, 3, 4};
    localparam int MB [NI] = '{65536, 65536, 256};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic        ireq [NI], iack [NI], dreq [NI], dwe [NI], dack [NI];
    logic [15:0] iaddr [NI], idin [NI], daddr [NI], ddout [NI], ddin [NI];
    logic [1:0]  dbe [NI];
    logic [47:0] led [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        risc16_mem_mmio #(.WAIT_CYCLES(WT[g]), .MEM_BYTES(MB[g])) u_dut (
            .clk(clk), .rst_n(rst_n),
            .ireq(ireq[g]), .iaddr(iaddr[g]), .idin(idin[g]), .iack(iack[g]),
            .dreq(dreq[g]), .dwe(dwe[g]), .dbe(dbe[g]), .daddr(daddr[g]),
            .ddout(ddout[g]), .ddin(ddin[g]), .dack(dack[g]), .led(led[g])
        );
    end

    // Model: memory bytes with a "written" flag, LED registers, and per-port start cycle.
    logic [7:0]  mm [NI][65536];
    bit          kn [NI][65536];
    logic [15:0] lm [NI][3];
    bit          pb [NI][2];
    int          ps [NI][2];
    int          cyc_n = 0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic logic [16:0] mrd(input int i, input logic [15:0] a, input bit mio);
        int w, e;
        w = int'(a) & 32'hFFFE;
        if (mio && w >= 'h200 && w < 'h206) return {1'b1, lm[i][(w - 'h200) / 2]};
        e = w & (MB[i] - 1);
        return {kn[i][e] & kn[i][e+1], mm[i][e], mm[i][e+1]};
    endfunction

    task automatic mwr(input int i);
        int w, e;
        w = int'(daddr[i]) & 32'hFFFE;
        if (w >= 'h200 && w < 'h206) begin
            if (dbe[i][1]) lm[i][(w - 'h200) / 2][15:8] = ddout[i][15:8];
            if (dbe[i][0]) lm[i][(w - 'h200) / 2][7:0]  = ddout[i][7:0];
        end else begin
            e = w & (MB[i] - 1);
            if (dbe[i][1]) begin mm[i][e]   = ddout[i][15:8]; kn[i][e]   = 1; end
            if (dbe[i][0]) begin mm[i][e+1] = ddout[i][7:0];  kn[i][e+1] = 1; end
        end
    endtask

    // An access starting at cycle s is acked in cycle s+W; the next may start at s+W+1.
    always @(negedge clk) begin
        bit          ea [2];
        logic        r;
        logic [16:0] rv;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) for (int k = 0; k < 3; k++) lm[i][k] = 16'h0000;
            for (int p = 0; p < 2; p++) begin
                r = (p == 1) ? dreq[i] : ireq[i];
                if (!rst_n) begin
                    pb[i][p] = 0;
                    ea[p] = 0;
                end else if (WT[i] == 0) begin
                    ea[p] = r;
                end else if (pb[i][p]) begin
                    ea[p] = (cyc_n == ps[i][p] + WT[i]);
                    if (!r && !ea[p]) $display("NOTE: inst %0d port %0d request dropped before ack", i, p);
                    if (ea[p]) pb[i][p] = 0;
                end else begin
                    ea[p] = 0;
                    if (r) begin pb[i][p] = 1; ps[i][p] = cyc_n; end
                end
            end
            chk($sformatf("iack[%0d]", i), iack[i], ea[0]);
            chk($sformatf("dack[%0d]", i), dack[i], ea[1]);
            rv = mrd(i, iaddr[i], 0);
            if (!ea[0]) chk($sformatf("idin idle[%0d]", i), idin[i], 16'h0000);
            else if (rv[16]) chk($sformatf("idin[%0d]", i), idin[i], rv[15:0]);
            rv = mrd(i, daddr[i], 1);
            if (!ea[1]) chk($sformatf("ddin idle[%0d]", i), ddin[i], 16'h0000);
            else if (!dwe[i] && rv[16]) chk($sformatf("ddin[%0d]", i), ddin[i], rv[15:0]);
            chk($sformatf("led[%0d]", i), led[i], {lm[i][2], lm[i][1], lm[i][0]});
            if (rst_n && ea[1] && dwe[i]) mwr(i);
        end
        cyc_n++;
    end

    task automatic acc(input int i, input int p, input bit we, input logic [1:0] be,
                       input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] q, output int lat);
        bit done = 0;
        q = 16'hxxxx;
        lat = -1;
        if (p == 0) begin ireq[i] = 1; iaddr[i] = a; end
        else begin dreq[i] = 1; dwe[i] = we; dbe[i] = be; daddr[i] = a; ddout[i] = d; end
        for (int k = 0; k < 32 && !done; k++) begin
            @(negedge clk);
            if (((p == 0) ? iack[i] : dack[i]) === 1'b1) begin
                done = 1;
                lat = k;
                q = (p == 0) ? idin[i] : ddin[i];
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack timeout inst %0d port %0d: no ack, expected one within 32 cycles", i, p);
        end
        @(posedge clk); #1;
        if (p == 0) ireq[i] = 0; else dreq[i] = 0;
    endtask

    initial begin
        logic [15:0] q;
        int          lat, nack;
        logic [15:0] pat;
        for (int i = 0; i < NI; i++) begin
            ireq[i] = 0; dreq[i] = 0; dwe[i] = 0; dbe[i] = 2'b00;
            iaddr[i] = 16'h0; daddr[i] = 16'h0; ddout[i] = 16'h0;
            for (int k = 0; k < 3; k++) lm[i][k] = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset dack", dack[i], 1'b0);
            chk("reset ddin", ddin[i], 16'h0000);
            chk("reset led", led[i], 48'h0);
        end
        @(posedge clk); #1;
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // Zero wait states, word write then read through the odd address.
        acc(0, 1, 1, 2'b11, 16'h0010, 16'hA55A, q, lat);
        chk("w0 write latency", lat, 0);
        acc(0, 1, 0, 2'b00, 16'h0011, 16'h0, q, lat);
        chk("w0 read data", q, 16'hA55A);
        chk("w0 read latency", lat, 0);
        acc(0, 0, 0, 2'b00, 16'h0010, 16'h0, q, lat);
        chk("w0 fetch data", q, 16'hA55A);
        acc(0, 1, 1, 2'b10, 16'h0011, 16'h77FF, q, lat);
        acc(0, 1, 0, 2'b00, 16'h0010, 16'h0, q, lat);
        chk("high byte enable", q, 16'h775A);

        // LED registers and byte enables.
        acc(0, 1, 1, 2'b11, 16'h0200, 16'h1234, q, lat);
        chk("led0 word", led[0][15:0], 16'h1234);
        acc(0, 1, 1, 2'b01, 16'h0202, 16'hBEEF, q, lat);
        chk("led1 low byte", led[0][31:16], 16'h00EF);
        acc(0, 1, 0, 2'b00, 16'h0202, 16'h0, q, lat);
        chk("led1 readback", q, 16'h00EF);
        acc(0, 1, 1, 2'b00, 16'h0204, 16'hFFFF, q, lat);
        chk("led2 no byte enable", led[0][47:32], 16'h0000);

        // Same-cycle data write and fetch of one word.
        acc(0, 1, 1, 2'b11, 16'h0020, 16'h1111, q, lat);
        dreq[0] = 1; dwe[0] = 1; dbe[0] = 2'b11; daddr[0] = 16'h0020; ddout[0] = 16'h2222;
        ireq[0] = 1; iaddr[0] = 16'h0020;
        @(negedge clk);
        chk("collision old word", idin[0], 16'h1111);
        @(posedge clk); #1;
        dreq[0] = 0;
        @(negedge clk);
        chk("collision new word", idin[0], 16'h2222);
        @(posedge clk); #1;
        ireq[0] = 0;

        // Three wait states, continuous reads.
        acc(1, 1, 1, 2'b11, 16'h0040, 16'h1357, q, lat);
        chk("w3 write latency", lat, 3);
        dreq[1] = 1; dwe[1] = 0; daddr[1] = 16'h0040;
        pat = 16'h0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            pat[k] = dack[1];
            if (dack[1]) chk("w3 burst data", ddin[1], 16'h1357);
        end
        @(posedge clk); #1;
        dreq[1] = 0;
        chk("w3 dack pattern", pat, 16'h8888);
        acc(1, 0, 0, 2'b00, 16'h0041, 16'h0, q, lat);
        chk("w3 fetch latency", lat, 3);
        chk("w3 fetch data", q, 16'h1357);

        // Four wait states: reset in the middle of a write.
        acc(2, 1, 1, 2'b11, 16'h0030, 16'h0BAD, q, lat);
        acc(2, 1, 1, 2'b11, 16'h0200, 16'h00FF, q, lat);
        chk("w4 led before reset", led[2][15:0], 16'h00FF);
        dreq[2] = 1; dwe[2] = 1; dbe[2] = 2'b11; daddr[2] = 16'h0030; ddout[2] = 16'hFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        dreq[2] = 0;
        @(negedge clk);
        chk("w4 led in reset", led[2], 48'h0);
        @(posedge clk); #1;
        rst_n = 1;
        nack = 0;
        repeat (10) begin
            @(negedge clk);
            if (dack[2]) nack++;
        end
        chk("w4 no ack after reset", nack, 0);
        @(posedge clk); #1;
        acc(2, 1, 0, 2'b00, 16'h0030, 16'h0, q, lat);
        chk("w4 aborted write", q, 16'h0BAD);
        chk("w4 read latency", lat, 4);

        // 256-byte memory: address wrap and MMIO window aliasing onto memory.
        acc(2, 1, 1, 2'b11, 16'h0105, 16'hCAFE, q, lat);
        acc(2, 1, 0, 2'b00, 16'h0004, 16'h0, q, lat);
        chk("wrap read", q, 16'hCAFE);
        acc(2, 1, 1, 2'b11, 16'h0000, 16'h5A5A, q, lat);
        acc(2, 1, 1, 2'b11, 16'h0200, 16'h1234, q, lat);
        acc(2, 0, 0, 2'b00, 16'h0200, 16'h0, q, lat);
        chk("fetch ignores mmio", q, 16'h5A5A);
        acc(2, 1, 0, 2'b00, 16'h0201, 16'h0, q, lat);
        chk("mmio read", q, 16'h1234);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
